// File: rtl/vend_mealy_param_if.sv
// Coin-side and actuator-side signals of the vending controller, bundled for port use.
// master = coin front end / bench, slave = controller.
interface vend_mealy_param_if #(
  parameter int CW    = 6,
  parameter int CNT_W = 8
);
  logic [1:0]       D_in;
  logic             Cancel;
  logic             D_out_mealy;
  logic             Change_pulse;
  logic             Coin_reject;
  logic [CW-1:0]    Credit;
  logic [CNT_W-1:0] Sales_cnt;

  modport master (
    output D_in, Cancel,
    input  D_out_mealy, Change_pulse, Coin_reject, Credit, Sales_cnt
  );

  modport slave (
    input  D_in, Cancel,
    output D_out_mealy, Change_pulse, Coin_reject, Credit, Sales_cnt
  );
endinterface

// File: rtl/vend_mealy_param.sv
// Mealy vending controller: coin credit accumulation, same-cycle dispense, unit-pulse refunds.
// Optional macro VEND_CHANGE_EN returns overpay as change pulses; otherwise overpay is kept.
module vend_mealy_param #(
  parameter int CW     = 6,
  parameter int PRICE  = 15,
  parameter int COIN_A = 5,
  parameter int COIN_B = 10,
  parameter int UNIT   = 5,
  parameter int CNT_W  = 8
) (
  input logic               Clk,
  input logic               Reset_n,
  vend_mealy_param_if.slave bus
);

  localparam int SW = CW + 1;
  localparam logic [SW-1:0] PRICE_V  = SW'(PRICE);
  localparam logic [SW-1:0] COIN_A_V = SW'(COIN_A);
  localparam logic [SW-1:0] COIN_B_V = SW'(COIN_B);
  localparam logic [CW-1:0] UNIT_V   = CW'(UNIT);

  typedef enum logic {COLLECT, REFUND} state_t;

  state_t           state;
  logic [CW-1:0]    credit;
  logic [CNT_W-1:0] sales;

  logic [SW-1:0] coin_val;
  logic [SW-1:0] sum;
  logic          buy;
  logic          refunding;

  always_comb begin
    coin_val = '0;
    if (bus.D_in[0]) coin_val = coin_val + COIN_A_V;
    if (bus.D_in[1]) coin_val = coin_val + COIN_B_V;
    sum = {1'b0, credit} + coin_val;
  end

  // Decoded outputs are forced low while reset is asserted.
  always_comb begin
    buy       = Reset_n && (state == COLLECT) && !bus.Cancel &&
                (coin_val != '0) && (sum >= PRICE_V);
    refunding = Reset_n && (state == REFUND);
  end

  assign bus.D_out_mealy  = buy;
  assign bus.Change_pulse = refunding;
  assign bus.Coin_reject  = refunding && (bus.D_in != 2'b00);
  assign bus.Credit       = credit;
  assign bus.Sales_cnt    = sales;

`ifdef VEND_CHANGE_EN
  logic [SW-1:0] rem;
  assign rem = sum - PRICE_V;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= COLLECT;
      credit <= '0;
      sales  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.Cancel) begin
            credit <= sum[CW-1:0];
            state  <= (sum != '0) ? REFUND : COLLECT;
          end else if (buy) begin
            sales <= sales + CNT_W'(1);
`ifdef VEND_CHANGE_EN
            credit <= rem[CW-1:0];
            state  <= (rem != '0) ? REFUND : COLLECT;
`else
            credit <= '0;
            state  <= COLLECT;
`endif
          end else begin
            credit <= sum[CW-1:0];
          end
        end
        REFUND: begin
          // Final pulse when only one unit remains; coins seen here are rejected.
          if (credit <= UNIT_V) begin
            credit <= '0;
            state  <= COLLECT;
          end else begin
            credit <= credit - UNIT_V;
          end
        end
        default: begin
          state  <= COLLECT;
          credit <= '0;
        end
      endcase
    end
  end

endmodule
